apb_dpmem_slave: RTL and testbench
==================================

Name: apb_dpmem_slave

Overview:
Parametrised APB4 slave that fronts a byte-enabled dual-port word memory. Port A is the APB bus. Port B is a native single-cycle port used by the local datapath or DMA.
Compared with the basic APB memory, it adds:
- generic address/data width and depth
- programmable wait states
- PSTRB byte writes
- PSLVERR error responses
- a read-only upper region
- defined cross-port collision handling

Parameters:
ADDR_WIDTH, 32, APB address width
DATA_WIDTH, 32, data width; must be 8, 16, 32 or 64
DEPTH, 256, memory depth in words; must be a power of two
WAIT_CYCLES, 1, extra ACCESS cycles before PREADY; valid range 0..15
RO_BASE, DEPTH, first read-only word index; DEPTH means no read-only region

Ports:
PCLK  in  1  clock, rising edge
PRESET  in  1  synchronous active-high reset
PSEL  in  1  slave select
PENABLE  in  1  access phase
PWRITE  in  1  1 = write, 0 = read
PADDR  in  ADDR_WIDTH  byte address
PWDATA  in  DATA_WIDTH  write data
PSTRB  in  DATA_WIDTH/8  byte write strobes
PRDATA  out  DATA_WIDTH  read data
PREADY  out  1  transfer complete
PSLVERR  out  1  error response, valid only while PREADY=1
b_en  in  1  port B request
b_we  in  1  port B write
b_addr  in  $clog2(DEPTH)  port B word index
b_wdata  in  DATA_WIDTH  port B write data
b_be  in  DATA_WIDTH/8  port B byte enables
b_rdata  out  DATA_WIDTH  port B read data, one cycle after b_en
b_collision  out  1  one-cycle pulse: port B write dropped

Behaviour:
- Reset, synchronous on PRESET=1:
  - FSM goes to IDLE, wait counter cleared.
  - PRDATA, PREADY, PSLVERR, b_rdata and b_collision are all 0.
  - Memory contents are not reset.
  - A transfer in flight is aborted and no write is committed.
- Address decode: LSB = $clog2(DATA_WIDTH/8); word index = PADDR[LSB +: $clog2(DEPTH)].
- An error is flagged when any of these holds:
  - PADDR[LSB-1:0] != 0 (misaligned)
  - PADDR >> LSB >= DEPTH (out of range)
  - PWRITE=1 and word index >= RO_BASE (read-only region)
- FSM, two states: IDLE and ACCESS.
  - IDLE, with PSEL=1 and PENABLE=0 (setup phase):
    - latch address, direction and error flag
    - load counter with WAIT_CYCLES
    - issue the synchronous memory read
    - go to ACCESS
  - IDLE, with PENABLE=1 and no prior setup: ignored, stay in IDLE.
  - ACCESS, with PSEL=1 and PENABLE=1:
    - counter != 0: decrement; PREADY=0.
    - counter == 0: PREADY=1, PSLVERR=error. The write commits at this edge if there is no error; only bytes with PSTRB[i]=1 are written. Next state is IDLE.
  - ACCESS, with PSEL dropped: go to IDLE; no write, no PREADY.
- Latency: the transfer lasts 2+WAIT_CYCLES cycles from setup. PREADY is high for exactly one cycle.
- PRDATA on read:
  - memory word, valid in the PREADY cycle
  - 0 on error
  - holds its last value otherwise
- PSLVERR is 0 whenever PREADY=0. A read with PSTRB != 0 is not an error; PSTRB is ignored on reads.
- Back-to-back transfers: a new setup is accepted in the cycle after PREADY.
- Port B:
  - b_en=1 with b_we=0: b_rdata updates at the next edge.
  - b_en=1 with b_we=1: byte-enabled write at the edge.
  - Port B ignores RO_BASE.
  - b_rdata holds its value when b_en=0.
- Collisions:
  - APB commit and port B write to the same word in the same cycle: APB wins, the port B write is dropped entirely, and b_collision=1 for that cycle.
  - Read-during-write to the same word from either side returns the old data.
  - Reads from both ports to the same word do not conflict.

Decomposition:
- apb_pkg gains:
  - state enum apb_state_e {IDLE, ACCESS}
  - localparam MAX_WAIT=15
  - function addr_lsb(DATA_WIDTH)
- apb_pkg keeps its existing addr_t and data_t (the slave instance uses the defaults).
- One sub-module: apb_dpram_core, a true dual-port RAM with per-port byte enables and synchronous read (old-data on read-during-write). The top holds the FSM, decode and collision logic.

Test Plan:
1. Reset, then APB write of 0xDEADBEEF to 0x10 with PSTRB=0xF and WAIT_CYCLES=1, then read of 0x10 -> PREADY high in the 3rd cycle of each transfer; PRDATA=0xDEADBEEF; PSLVERR=0.
2. Write of 0x11223344 to 0x20, then write of 0xAABBCCDD to 0x20 with PSTRB=0x5, then read -> 0x11BB33DD.
3. Read of 0x402 (misaligned), read of 0x400 (word 256, out of range), and write to word RO_BASE (RO_BASE=0xF0) -> PSLVERR=1 with PREADY; PRDATA=0; memory unchanged.
4. APB write of 0x1 and port B write of 0x2 to word 5 committing in the same cycle -> b_collision=1 for one cycle; a subsequent port B read of word 5 returns 0x1.
5. WAIT_CYCLES=0, back-to-back reads of 0x0 and 0x4 -> PREADY high in the 2nd cycle of each; no idle cycle is needed between them.
6. PRESET asserted during ACCESS of a write of 0xCAFE to 0x8 -> outputs are 0 the next cycle; word 2 keeps its old value.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types, FSM encoding and address helpers for the APB memory slave.
package apb_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;

    typedef enum logic {IDLE, ACCESS} apb_state_e;

    localparam int unsigned MAX_WAIT = 15;

    function automatic int unsigned addr_lsb(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/apb_dpram_core.sv
// True dual-port word RAM with per-port byte enables and registered reads.
// A read that coincides with a write to the same word returns the old contents.
module apb_dpram_core #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned IDX_W      = $clog2(DEPTH),
    parameter int unsigned BE_W       = DATA_WIDTH / 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_a_en,
    input  logic                  i_a_we,
    input  logic [IDX_W-1:0]      i_a_addr,
    input  logic [DATA_WIDTH-1:0] i_a_wdata,
    input  logic [BE_W-1:0]       i_a_be,
    output logic [DATA_WIDTH-1:0] o_a_rdata,
    input  logic                  i_b_en,
    input  logic                  i_b_we,
    input  logic [IDX_W-1:0]      i_b_addr,
    input  logic [DATA_WIDTH-1:0] i_b_wdata,
    input  logic [BE_W-1:0]       i_b_be,
    output logic [DATA_WIDTH-1:0] o_b_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_a_rdata;
    logic [DATA_WIDTH-1:0] r_b_rdata;

    // Contents are deliberately not reset.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < int'(BE_W); i++) begin
            if (i_a_en && i_a_we && i_a_be[i]) begin
                r_mem[i_a_addr][8*i +: 8] <= i_a_wdata[8*i +: 8];
            end
            if (i_b_en && i_b_we && i_b_be[i]) begin
                r_mem[i_b_addr][8*i +: 8] <= i_b_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a_rdata <= '0;
            r_b_rdata <= '0;
        end else begin
            if (i_a_en && !i_a_we) begin
                r_a_rdata <= r_mem[i_a_addr];
            end
            if (i_b_en && !i_b_we) begin
                r_b_rdata <= r_mem[i_b_addr];
            end
        end
    end

    assign o_a_rdata = r_a_rdata;
    assign o_b_rdata = r_b_rdata;

endmodule

// File: rtl/apb_dpmem_slave.sv
// APB4 slave in front of a byte-enabled dual-port RAM; port B is a native datapath port.
// Holds the transfer FSM, address/error decode and cross-port write arbitration.
module apb_dpmem_slave
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned RO_BASE     = DEPTH
) (
    input  logic                      PCLK,
    input  logic                      PRESET,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    input  logic                      PWRITE,
    input  logic [ADDR_WIDTH-1:0]     PADDR,
    input  logic [DATA_WIDTH-1:0]     PWDATA,
    input  logic [DATA_WIDTH/8-1:0]   PSTRB,
    output logic [DATA_WIDTH-1:0]     PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic                      b_en,
    input  logic                      b_we,
    input  logic [$clog2(DEPTH)-1:0]  b_addr,
    input  logic [DATA_WIDTH-1:0]     b_wdata,
    input  logic [DATA_WIDTH/8-1:0]   b_be,
    output logic [DATA_WIDTH-1:0]     b_rdata,
    output logic                      b_collision
);

    localparam int unsigned LSB   = addr_lsb(DATA_WIDTH);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned BE_W  = DATA_WIDTH / 8;
    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [ADDR_WIDTH-1:0] OFS_MASK = ADDR_WIDTH'((64'd1 << LSB) - 64'd1);

    apb_state_e             r_state;
    apb_state_e             w_state_next;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_next;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_write;
    logic                   r_err;
    logic [DATA_WIDTH-1:0]  r_prdata;

    logic [ADDR_WIDTH-1:0]  w_word_full;
    logic [IDX_W-1:0]       w_idx;
    logic                   w_err;
    logic                   w_setup;
    logic                   w_done;
    logic                   w_ready;
    logic                   w_a_commit;
    logic                   w_a_en;
    logic [IDX_W-1:0]       w_a_addr;
    logic [DATA_WIDTH-1:0]  w_a_rdata;
    logic [DATA_WIDTH-1:0]  w_rd_value;
    logic                   w_collision;

    assign w_word_full = PADDR >> LSB;
    assign w_idx       = PADDR[LSB +: IDX_W];
    assign w_err       = (|(PADDR & OFS_MASK))
                      || (w_word_full >= ADDR_WIDTH'(DEPTH))
                      || (PWRITE && (w_word_full >= ADDR_WIDTH'(RO_BASE)));

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_setup      = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    w_setup      = 1'b1;
                    w_cnt_next   = CNT_W'(WAIT_CYCLES);
                    w_state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (PSEL && PENABLE) begin
                    if (r_cnt != '0) begin
                        w_cnt_next = r_cnt - 1'b1;
                    end else begin
                        w_done       = 1'b1;
                        w_state_next = IDLE;
                    end
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Gating by PRESET aborts a transfer whose completion edge coincides with reset.
    assign w_ready     = w_done && !PRESET;
    assign w_a_commit  = w_ready && r_write && !r_err;
    assign w_a_en      = w_setup || w_a_commit;
    assign w_a_addr    = w_setup ? w_idx : r_idx;
    assign w_collision = w_a_commit && b_en && b_we && (b_addr == r_idx);
    assign w_rd_value  = r_err ? '0 : w_a_rdata;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_write  <= 1'b0;
            r_err    <= 1'b0;
            r_prdata <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_setup) begin
                r_idx   <= w_idx;
                r_write <= PWRITE;
                r_err   <= w_err;
            end
            if (w_ready && !r_write) begin
                r_prdata <= w_rd_value;
            end
        end
    end

    // A colliding port B write is dropped outright, including its enable.
    apb_dpram_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W),
        .BE_W       (BE_W)
    ) u_core (
        .i_clk     (PCLK),
        .i_rst     (PRESET),
        .i_a_en    (w_a_en),
        .i_a_we    (w_a_commit),
        .i_a_addr  (w_a_addr),
        .i_a_wdata (PWDATA),
        .i_a_be    (PSTRB),
        .o_a_rdata (w_a_rdata),
        .i_b_en    (b_en && !w_collision),
        .i_b_we    (b_we),
        .i_b_addr  (b_addr),
        .i_b_wdata (b_wdata),
        .i_b_be    (b_be),
        .o_b_rdata (b_rdata)
    );

    assign PREADY      = w_ready;
    assign PSLVERR     = w_ready && r_err;
    assign PRDATA      = (w_ready && !r_write) ? w_rd_value : r_prdata;
    assign b_collision = w_collision;

endmodule

// File: tb/tb_apb_dpmem_slave.sv
// Directed bench: one slave with one wait state and a read-only top region, one zero-wait slave.
module tb_apb_dpmem_slave;

    logic        PCLK = 1'b0;
    logic        PRESET, PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA;
    logic [3:0]  PSTRB;
    logic        b_en, b_we;
    logic [7:0]  b_addr;
    logic [31:0] b_wdata;
    logic [3:0]  b_be;

    logic [31:0] prdata1, b_rdata1, prdata0, b_rdata0;
    logic        pready1, pslverr1, b_coll1, pready0, pslverr0, b_coll0;

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;

    logic [31:0] rd;
    logic        err;
    int          cyc;

    always #5 PCLK = ~PCLK;

    apb_dpmem_slave #(
        .ADDR_WIDTH (32), .DATA_WIDTH (32), .DEPTH (256), .WAIT_CYCLES (1), .RO_BASE (240)
    ) u_dut1 (
        .PCLK (PCLK), .PRESET (PRESET), .PSEL (PSEL), .PENABLE (PENABLE), .PWRITE (PWRITE),
        .PADDR (PADDR), .PWDATA (PWDATA), .PSTRB (PSTRB), .PRDATA (prdata1), .PREADY (pready1),
        .PSLVERR (pslverr1), .b_en (b_en), .b_we (b_we), .b_addr (b_addr), .b_wdata (b_wdata),
        .b_be (b_be), .b_rdata (b_rdata1), .b_collision (b_coll1)
    );

    apb_dpmem_slave #(
        .ADDR_WIDTH (32), .DATA_WIDTH (32), .DEPTH (256), .WAIT_CYCLES (0), .RO_BASE (256)
    ) u_dut0 (
        .PCLK (PCLK), .PRESET (PRESET), .PSEL (PSEL), .PENABLE (PENABLE), .PWRITE (PWRITE),
        .PADDR (PADDR), .PWDATA (PWDATA), .PSTRB (PSTRB), .PRDATA (prdata0), .PREADY (pready0),
        .PSLVERR (pslverr0), .b_en (b_en), .b_we (b_we), .b_addr (b_addr), .b_wdata (b_wdata),
        .b_be (b_be), .b_rdata (b_rdata0), .b_collision (b_coll0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Full APB transfer observed on the one-wait-state slave; cyc=0 means PREADY never came.
    task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, output logic [31:0] rdo, output logic erro,
                       output int cyco);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data; PSTRB = strb;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        cyco = 0; rdo = '0; erro = 1'b0;
        for (int c = 2; c <= 20; c++) begin
            @(negedge PCLK);
            if (pready1 === 1'b1) begin
                cyco = c; rdo = prdata1; erro = pslverr1;
                break;
            end
            @(posedge PCLK); #1;
        end
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic pb_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        @(posedge PCLK); #1;
        b_en = 1'b1; b_we = 1'b1; b_addr = a; b_wdata = d; b_be = be;
        @(posedge PCLK); #1;
        b_en = 1'b0; b_we = 1'b0;
    endtask

    task automatic pb_read(input logic [7:0] a, output logic [31:0] d);
        @(posedge PCLK); #1;
        b_en = 1'b1; b_we = 1'b0; b_addr = a;
        @(posedge PCLK); #1;
        b_en = 1'b0;
        @(negedge PCLK);
        d = b_rdata1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; PSTRB = '0;
        b_en = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_be = '0;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        chk("rst_pready", 32'(pready1), 32'd0);
        chk("rst_pslverr", 32'(pslverr1), 32'd0);
        chk("rst_prdata", prdata1, 32'd0);
        chk("rst_b_rdata", b_rdata1, 32'd0);
        chk("rst_b_coll", 32'(b_coll1), 32'd0);
        @(posedge PCLK); #1;
        PRESET = 1'b0;

        // Basic write/read with one wait state.
        apb(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, err, cyc);
        chk("t1_wr_cycle", 32'(cyc), 32'd3);
        chk("t1_wr_err", 32'(err), 32'd0);
        apb(1'b0, 32'h10, 32'h0, 4'h0, rd, err, cyc);
        chk("t1_rd_cycle", 32'(cyc), 32'd3);
        chk("t1_rd_data", rd, 32'hDEADBEEF);
        chk("t1_rd_err", 32'(err), 32'd0);
        pb_read(8'd4, rd);
        chk("t1_portb_rd", rd, 32'hDEADBEEF);

        // Byte strobes; PSTRB on a read must not raise an error.
        apb(1'b1, 32'h20, 32'h11223344, 4'hF, rd, err, cyc);
        apb(1'b1, 32'h20, 32'hAABBCCDD, 4'h5, rd, err, cyc);
        apb(1'b0, 32'h20, 32'h0, 4'hF, rd, err, cyc);
        chk("t2_strb_data", rd, 32'h11BB33DD);
        chk("t2_rd_strb_err", 32'(err), 32'd0);

        // Error responses: misaligned, out of range, read-only write.
        pb_write(8'hF0, 32'h55AA55AA, 4'hF);
        apb(1'b0, 32'h402, 32'h0, 4'h0, rd, err, cyc);
        chk("t3_misal_err", 32'(err), 32'd1);
        chk("t3_misal_data", rd, 32'd0);
        apb(1'b0, 32'h400, 32'h0, 4'h0, rd, err, cyc);
        chk("t3_oor_err", 32'(err), 32'd1);
        chk("t3_oor_data", rd, 32'd0);
        apb(1'b1, 32'h3C0, 32'h12345678, 4'hF, rd, err, cyc);
        chk("t3_ro_err", 32'(err), 32'd1);
        chk("t3_ro_cycle", 32'(cyc), 32'd3);
        chk("t3_ro_prdata", rd, 32'd0);
        apb(1'b0, 32'h3C0, 32'h0, 4'h0, rd, err, cyc);
        chk("t3_ro_unchanged", rd, 32'h55AA55AA);
        chk("t3_ro_rd_err", 32'(err), 32'd0);

        // Same-word write collision in the APB commit cycle.
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h14; PWDATA = 32'h1; PSTRB = 4'hF;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        b_en = 1'b1; b_we = 1'b1; b_addr = 8'd5; b_wdata = 32'h2; b_be = 4'hF;
        @(negedge PCLK);
        chk("t4_pready", 32'(pready1), 32'd1);
        chk("t4_coll", 32'(b_coll1), 32'd1);
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; b_en = 1'b0; b_we = 1'b0;
        @(negedge PCLK);
        chk("t4_coll_pulse", 32'(b_coll1), 32'd0);
        pb_read(8'd5, rd);
        chk("t4_apb_wins", rd, 32'h1);

        // Reset in the would-be commit cycle aborts the write.
        apb(1'b1, 32'h8, 32'h0BADF00D, 4'hF, rd, err, cyc);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h8; PWDATA = 32'hCAFE; PSTRB = 4'hF;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PRESET = 1'b1;
        @(negedge PCLK);
        chk("t6_no_ready", 32'(pready1), 32'd0);
        @(posedge PCLK); #1;
        PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        chk("t6_prdata", prdata1, 32'd0);
        chk("t6_pready", 32'(pready1), 32'd0);
        chk("t6_pslverr", 32'(pslverr1), 32'd0);
        chk("t6_b_rdata", b_rdata1, 32'd0);
        chk("t6_b_coll", 32'(b_coll1), 32'd0);
        apb(1'b0, 32'h8, 32'h0, 4'h0, rd, err, cyc);
        chk("t6_word_kept", rd, 32'h0BADF00D);

        // Zero-wait slave, back-to-back reads.
        apb(1'b1, 32'h0, 32'h0A0A0A0A, 4'hF, rd, err, cyc);
        apb(1'b1, 32'h4, 32'h1B1B1B1B, 4'hF, rd, err, cyc);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h0; PSTRB = 4'h0;
        @(negedge PCLK);
        chk("t5_setup0_ready", 32'(pready0), 32'd0);
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(negedge PCLK);
        chk("t5_rd0_ready", 32'(pready0), 32'd1);
        chk("t5_rd0_data", prdata0, 32'h0A0A0A0A);
        chk("t5_rd0_err", 32'(pslverr0), 32'd0);
        @(posedge PCLK); #1;
        PENABLE = 1'b0; PADDR = 32'h4;
        @(negedge PCLK);
        chk("t5_setup1_ready", 32'(pready0), 32'd0);
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(negedge PCLK);
        chk("t5_rd1_ready", 32'(pready0), 32'd1);
        chk("t5_rd1_data", prdata0, 32'h1B1B1B1B);
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        chk("t5_idle_ready", 32'(pready0), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
